// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Goldschmidt divider controller and datapath.
// Holds the FSM state encoding and the operand-mux select codes.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_Q,
        S_INIT_D,
        S_ITER_Q,
        S_ITER_D,
        S_DONE
    } state_t;

    // Multiplier operand A: rega (K), divisor d, initial approximation ia
    localparam logic [1:0] MUXA_REGA = 2'b00;
    localparam logic [1:0] MUXA_D    = 2'b01;
    localparam logic [1:0] MUXA_IA   = 2'b10;

    // Multiplier operand B: divisor d, dividend x, regb (Q), regc (D)
    localparam logic [1:0] MUXB_D    = 2'b00;
    localparam logic [1:0] MUXB_X    = 2'b01;
    localparam logic [1:0] MUXB_REGB = 2'b10;
    localparam logic [1:0] MUXB_REGC = 2'b11;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt division sequencer: steers the shared multiplier between the
// quotient (Q) and divisor (D) chains for N_ITER refinement iterations.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int N_ITER = 3,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       d_zero,
    output logic       busy,
    output logic       done,
    output logic       dbz,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       loada,
    output logic       loadb,
    output logic       loadc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    assign accept = (state == S_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                dbz <= d_zero;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b1;
        done      = 1'b0;
        sel_muxa  = MUXA_REGA;
        sel_muxb  = MUXB_D;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = d_zero ? S_DONE : S_INIT_Q;
                end
            end
            S_INIT_Q: begin
                sel_muxa  = MUXA_IA;
                sel_muxb  = MUXB_X;
                loadb     = 1'b1;
                state_nxt = S_INIT_D;
            end
            S_INIT_D: begin
                sel_muxa  = MUXA_IA;
                sel_muxb  = MUXB_D;
                loadc     = 1'b1;
                loada     = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_ITER_Q;
            end
            S_ITER_Q: begin
                sel_muxa  = MUXA_REGA;
                sel_muxb  = MUXB_REGB;
                loadb     = 1'b1;
                state_nxt = S_ITER_D;
            end
            S_ITER_D: begin
                sel_muxa = MUXA_REGA;
                sel_muxb = MUXB_REGC;
                loadc    = 1'b1;
                loada    = 1'b1;
                // Stop at the last iteration so the counter can never wrap
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = S_ITER_Q;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: per-cycle output table for one division
// plus sequences for divide-by-zero, ignored start, reset abort, held start.
module tb_fpdiv_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       d_zero;
    logic       busy;
    logic       done;
    logic       dbz;
    logic [1:0] sel_muxa;
    logic [1:0] sel_muxb;
    logic       loada;
    logic       loadb;
    logic       loadc;

    int checks = 0;
    int errors = 0;

    fpdiv_ctrl #(.N_ITER(3), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .d_zero   (d_zero),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .sel_muxa (sel_muxa),
        .sel_muxb (sel_muxb),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc)
    );

    always #5 clk = ~clk;

    // {busy, done, dbz, sel_muxa, sel_muxb, loada, loadb, loadc}
    typedef struct {
        string      name;
        logic [9:0] exp;
    } vec_t;

    localparam logic [9:0] V_IDLE  = 10'b0_0_0_00_00_000;
    localparam logic [9:0] V_INITQ = 10'b1_0_0_10_01_010;
    localparam logic [9:0] V_INITD = 10'b1_0_0_10_00_101;
    localparam logic [9:0] V_ITERQ = 10'b1_0_0_00_10_010;
    localparam logic [9:0] V_ITERD = 10'b1_0_0_00_11_101;
    localparam logic [9:0] V_DONE  = 10'b1_1_0_00_00_000;

    vec_t tbl[10];

    function automatic logic [9:0] outs();
        return {busy, done, dbz, sel_muxa, sel_muxb, loada, loadb, loadc};
    endfunction

    task automatic check_vec(input string name, input logic [9:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, outs(), exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic inv_check();
        checks++;
        if ((loadb && loadc) || (loada && !loadc)) begin
            errors++;
            $display("FAIL load_excl: loada=%b loadb=%b loadc=%b",
                     loada, loadb, loadc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs n cycles; start stays high while c < hold, plus one pulse at c==pulse
    task automatic watch(input int n, input int hold, input int pulse,
                         output int cnt, output int c1, output int c2);
        cnt = 0;
        c1  = -1;
        c2  = -1;
        for (int c = 1; c <= n; c++) begin
            step();
            start = (c < hold) || (c == pulse);
            inv_check();
            if (done) begin
                cnt++;
                if (c1 < 0) c1 = c;
                else if (c2 < 0) c2 = c;
            end
        end
    endtask

    int n_done;
    int d1;
    int d2;

    initial begin
        tbl[0] = '{"c1_init_q",  V_INITQ};
        tbl[1] = '{"c2_init_d",  V_INITD};
        tbl[2] = '{"c3_iter_q1", V_ITERQ};
        tbl[3] = '{"c4_iter_d1", V_ITERD};
        tbl[4] = '{"c5_iter_q2", V_ITERQ};
        tbl[5] = '{"c6_iter_d2", V_ITERD};
        tbl[6] = '{"c7_iter_q3", V_ITERQ};
        tbl[7] = '{"c8_iter_d3", V_ITERD};
        tbl[8] = '{"c9_done",    V_DONE};
        tbl[9] = '{"c10_idle",   V_IDLE};

        reset  = 1'b1;
        start  = 1'b0;
        d_zero = 1'b0;
        @(negedge clk);
        check_vec("reset_state", V_IDLE);
        step();
        reset = 1'b0;
        step();
        check_vec("idle_after_reset", V_IDLE);

        // Divide by zero: straight to DONE, flag held afterwards
        start  = 1'b1;
        d_zero = 1'b1;
        step();
        start  = 1'b0;
        d_zero = 1'b0;
        check_vec("dbz_done", 10'b1_1_1_00_00_000);
        step();
        check_vec("dbz_held_idle", 10'b0_0_1_00_00_000);
        step();
        check_vec("dbz_held_idle2", 10'b0_0_1_00_00_000);

        // Normal division, per-cycle table; also shows dbz cleared on accept
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            start = 1'b0;
            check_vec(tbl[i].name, tbl[i].exp);
            inv_check();
        end

        // Start pulsed again during cycle 4 must be ignored
        start = 1'b1;
        watch(16, 1, 4, n_done, d1, d2);
        check_int("ignore_count", n_done, 1);
        check_int("ignore_cycle", d1, 9);

        // Reset during ITER_Q of iteration 2 aborts immediately
        start = 1'b1;
        watch(5, 1, -1, n_done, d1, d2);
        check_vec("pre_abort_iter_q2", V_ITERQ);
        check_int("pre_abort_no_done", n_done, 0);
        reset = 1'b1;
        #1;
        check_vec("abort_async", V_IDLE);
        step();
        check_vec("abort_held", V_IDLE);
        reset = 1'b0;
        watch(12, 0, -1, n_done, d1, d2);
        check_int("abort_no_done", n_done, 0);
        start = 1'b1;
        watch(12, 1, -1, n_done, d1, d2);
        check_int("post_abort_count", n_done, 1);
        check_int("post_abort_cycle", d1, 9);

        // Start held for 25 cycles: back-to-back divisions
        start = 1'b1;
        watch(25, 25, -1, n_done, d1, d2);
        check_int("held_count", n_done, 2);
        check_int("held_first", d1, 9);
        check_int("held_second", d2, 19);
        start = 1'b0;
        watch(12, 0, -1, n_done, d1, d2);
        check_vec("final_idle", V_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
